openmips_cpu: RTL and testbench

//  Minimal 5-stage (IF/ID/EX/MEM/WB) in-order MIPS32 integer core for the FPGA bring-up flow.

---
 rtl/openmips_pkg.sv | 46 ++++
 rtl/openmips_regfile.sv | 45 ++++
 rtl/openmips_cpu.sv | 146 ++++++++++++++
 tb/tb_openmips_cpu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/openmips_pkg.sv
// Shared constants, encodings and stage payload types for the openmips integer core.
package openmips_pkg;

  localparam logic RST_ENABLE = 1'b0;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;
  localparam int REG_BUS       = 32;
  localparam int REG_ADDR_BUS  = 5;
  localparam int NUM_REGS      = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_AND = 3'd1,
    ALU_OR  = 3'd2,
    ALU_XOR = 3'd3,
    ALU_NOR = 3'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e                 alu_op;
    logic [REG_BUS-1:0]      op1;
    logic [REG_BUS-1:0]      op2;
    logic                    wreg;
    logic [REG_ADDR_BUS-1:0] waddr;
  } id_ex_t;

  // Payload carried from EX onwards: a pending register write.
  typedef struct packed {
    logic                    wreg;
    logic [REG_ADDR_BUS-1:0] waddr;
    logic [REG_BUS-1:0]      wdata;
  } wb_t;

endpackage

// File: rtl/openmips_regfile.sv
// 32x32 GPR file: two combinational read ports with write-through, one synchronous write port.
module openmips_regfile
  import openmips_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [REG_ADDR_BUS-1:0] waddr,
  input  logic [REG_BUS-1:0]      wdata,
  input  logic [REG_ADDR_BUS-1:0] raddr1,
  output logic [REG_BUS-1:0]      rdata1,
  input  logic [REG_ADDR_BUS-1:0] raddr2,
  output logic [REG_BUS-1:0]      rdata2
);

  logic [REG_BUS-1:0]      regs [0:NUM_REGS-1];
  logic [REG_ADDR_BUS-1:0] raddr [0:1];
  logic [REG_BUS-1:0]      rdata [0:1];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;
  assign rdata1   = rdata[0];
  assign rdata2   = rdata[1];

  // $0 is hardwired; a write landing this cycle is visible to the reader in ID.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      assign rdata[gi] = (raddr[gi] == '0)                 ? '0    :
                         (we && (waddr == raddr[gi]))      ? wdata :
                                                             regs[raddr[gi]];
    end
  endgenerate

endmodule

// File: rtl/openmips_cpu.sv
// Five-stage in-order MIPS32 logical/immediate core; fetches from an external combinational ROM.
module openmips_cpu
  import openmips_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_ADDR_BUS-1:0] PC_STEP  = 32'd4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INST_BUS-1:0]      rom_data_i,
  output logic [INST_ADDR_BUS-1:0] rom_addr_o,
  output logic                     rom_ce_o
);

  logic [INST_ADDR_BUS-1:0] pc_reg;
  logic                     ce_reg;
  logic [INST_BUS-1:0]      if_id_reg;
  id_ex_t                   id_ex_reg, id_ex_next;
  wb_t                      ex_mem_reg, ex_mem_next;
  wb_t                      mem_wb_reg;

  logic [5:0]               opcode, funct;
  logic [REG_ADDR_BUS-1:0]  rs, rt, rd;
  logic [15:0]              imm;
  logic [REG_BUS-1:0]       rf_rdata1, rf_rdata2, rs_val, rt_val;

  assign rom_addr_o = pc_reg;
  assign rom_ce_o   = ce_reg;

  // Fetch: the first enabled edge only raises ce, so RESET_PC is presented for a full cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      ce_reg    <= 1'b0;
      pc_reg    <= RESET_PC;
      if_id_reg <= '0;
    end else begin
      ce_reg    <= 1'b1;
      if (ce_reg) begin
        pc_reg <= pc_reg + PC_STEP;
      end
      if_id_reg <= ce_reg ? rom_data_i : '0;
    end
  end

  assign opcode = if_id_reg[31:26];
  assign rs     = if_id_reg[25:21];
  assign rt     = if_id_reg[20:16];
  assign rd     = if_id_reg[15:11];
  assign funct  = if_id_reg[5:0];
  assign imm    = if_id_reg[15:0];

  openmips_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (mem_wb_reg.wreg),
    .waddr  (mem_wb_reg.waddr),
    .wdata  (mem_wb_reg.wdata),
    .raddr1 (rs),
    .rdata1 (rf_rdata1),
    .raddr2 (rt),
    .rdata2 (rf_rdata2)
  );

  // Youngest producer wins; $0 is never bypassed so it always reads as zero.
  function automatic logic [REG_BUS-1:0] bypass(
    input logic [REG_ADDR_BUS-1:0] addr,
    input logic [REG_BUS-1:0]      rf_data,
    input wb_t                     ex_stage,
    input wb_t                     mem_stage
  );
    if ((addr != '0) && ex_stage.wreg && (ex_stage.waddr == addr)) begin
      return ex_stage.wdata;
    end else if ((addr != '0) && mem_stage.wreg && (mem_stage.waddr == addr)) begin
      return mem_stage.wdata;
    end
    return rf_data;
  endfunction

  assign rs_val = bypass(rs, rf_rdata1, ex_mem_next, ex_mem_reg);
  assign rt_val = bypass(rt, rf_rdata2, ex_mem_next, ex_mem_reg);

  always_comb begin
    id_ex_next = '0;
    case (opcode)
      OP_ORI, OP_ANDI, OP_XORI: begin
        id_ex_next.alu_op = (opcode == OP_ORI)  ? ALU_OR  :
                            (opcode == OP_ANDI) ? ALU_AND : ALU_XOR;
        id_ex_next.op1    = rs_val;
        id_ex_next.op2    = {16'h0000, imm};
        id_ex_next.wreg   = 1'b1;
        id_ex_next.waddr  = rt;
      end
      OP_LUI: begin
        // LUI is an OR of the shifted immediate into zero.
        id_ex_next.alu_op = ALU_OR;
        id_ex_next.op1    = '0;
        id_ex_next.op2    = {imm, 16'h0000};
        id_ex_next.wreg   = 1'b1;
        id_ex_next.waddr  = rt;
      end
      OP_SPECIAL: begin
        case (funct)
          FN_AND: id_ex_next.alu_op = ALU_AND;
          FN_OR:  id_ex_next.alu_op = ALU_OR;
          FN_XOR: id_ex_next.alu_op = ALU_XOR;
          FN_NOR: id_ex_next.alu_op = ALU_NOR;
          default: id_ex_next.alu_op = ALU_NOP;
        endcase
        if (id_ex_next.alu_op != ALU_NOP) begin
          id_ex_next.op1   = rs_val;
          id_ex_next.op2   = rt_val;
          id_ex_next.wreg  = 1'b1;
          id_ex_next.waddr = rd;
        end
      end
      default: id_ex_next = '0;
    endcase
  end

  always_comb begin
    ex_mem_next       = '0;
    ex_mem_next.wreg  = id_ex_reg.wreg;
    ex_mem_next.waddr = id_ex_reg.waddr;
    case (id_ex_reg.alu_op)
      ALU_AND: ex_mem_next.wdata = id_ex_reg.op1 & id_ex_reg.op2;
      ALU_OR:  ex_mem_next.wdata = id_ex_reg.op1 | id_ex_reg.op2;
      ALU_XOR: ex_mem_next.wdata = id_ex_reg.op1 ^ id_ex_reg.op2;
      ALU_NOR: ex_mem_next.wdata = ~(id_ex_reg.op1 | id_ex_reg.op2);
      default: ex_mem_next.wdata = '0;
    endcase
  end

  // MEM has no memory access yet, so it simply forwards the EX result to WB.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      id_ex_reg  <= '0;
      ex_mem_reg <= '0;
      mem_wb_reg <= '0;
    end else begin
      id_ex_reg  <= id_ex_next;
      ex_mem_reg <= ex_mem_next;
      mem_wb_reg <= ex_mem_reg;
    end
  end

endmodule

// File: tb/tb_openmips_cpu.sv
// Directed bench for openmips_cpu: fetch sequencing, writeback timing, bypassing, $0/NOP and reset.
module tb_openmips_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rom_data;
  logic [31:0] rom_addr;
  logic        rom_ce;
  logic [31:0] rom [0:63];

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  assign rom_data = rom[rom_addr[7:2]];

  openmips_cpu dut (
    .clk        (clk),
    .rst        (rst),
    .rom_data_i (rom_data),
    .rom_addr_o (rom_addr),
    .rom_ce_o   (rom_ce)
  );

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic clear_rom(input logic [31:0] fill);
    for (int i = 0; i < 64; i++) rom[i] = fill;
  endtask

  // Reset released between edges; the next rising edge is E1 (ce rises, PC stays 0).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_rom(enc_i(6'h0D, 5'd0, 5'd9, 16'hbeef));
    #25;
    checks++;
    if (rom_ce !== 1'b0) begin
      errors++; $display("FAIL reset_ce: got %b expected 0", rom_ce);
    end
    checks++;
    if (rom_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 00000000", rom_addr);
    end
    wait ($time >= 73);
    rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      next_edge();
      checks++;
      if (rom_ce !== 1'b1) begin
        errors++; $display("FAIL fetch_ce edge %0d: got %b expected 1", e, rom_ce);
      end
      checks++;
      if (rom_addr !== 32'((e - 1) * 4)) begin
        errors++; $display("FAIL fetch_addr edge %0d: got %h expected %h", e, rom_addr, 32'((e - 1) * 4));
      end
    end
    $display("test_reset: done, %0d errors so far", errors);
  endtask

  task automatic load_imm_prog();
    clear_rom(32'h0);
    rom[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'h1100);
    rom[1] = enc_i(6'h0D, 5'd0, 5'd2, 16'h0020);
    rom[2] = enc_i(6'h0D, 5'd0, 5'd3, 16'hff00);
    rom[3] = enc_i(6'h0D, 5'd0, 5'd4, 16'hffff);
  endtask

  // Instruction k is fetched in the cycle after E(k+1) and must land in the GPR exactly at E(k+6).
  task automatic check_imm_timing(input string tag);
    logic [31:0] vals [0:3];
    logic [31:0] exp_v;
    vals[0] = 32'h0000_1100; vals[1] = 32'h0000_0020;
    vals[2] = 32'h0000_ff00; vals[3] = 32'h0000_ffff;
    for (int e = 1; e <= 10; e++) begin
      next_edge();
      if (e == 2) begin
        checks++;
        if (rom_addr !== 32'h4) begin
          errors++; $display("FAIL %s_addr: got %h expected 00000004", tag, rom_addr);
        end
      end
      if (e >= 5) begin
        for (int k = 0; k < 4; k++) begin
          exp_v = (e >= 6 + k) ? vals[k] : 32'h0;
          checks++;
          if (dut.u_regfile.regs[k + 1] !== exp_v) begin
            errors++;
            $display("FAIL %s edge %0d $%0d: got %h expected %h", tag, e, k + 1,
                     dut.u_regfile.regs[k + 1], exp_v);
          end
        end
      end
    end
  endtask

  task automatic test_immediates();
    load_imm_prog();
    do_reset();
    check_imm_timing("imm");
    $display("test_immediates: done, %0d errors so far", errors);
  endtask

  task automatic test_forward_chain();
    logic [31:0] exp_v;
    clear_rom(32'h0);
    rom[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'h1100);
    rom[1] = enc_i(6'h0D, 5'd1, 5'd1, 16'h0020);
    rom[2] = enc_i(6'h0D, 5'd1, 5'd1, 16'h4400);
    rom[3] = enc_i(6'h0D, 5'd1, 5'd1, 16'h0044);
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      next_edge();
      case (e)
        6:       exp_v = 32'h0000_1100;
        7:       exp_v = 32'h0000_1120;
        8:       exp_v = 32'h0000_5520;
        9, 10:   exp_v = 32'h0000_5564;
        default: exp_v = 32'h0;
      endcase
      if (e >= 5) begin
        checks++;
        if (dut.u_regfile.regs[1] !== exp_v) begin
          errors++; $display("FAIL chain edge %0d $1: got %h expected %h", e, dut.u_regfile.regs[1], exp_v);
        end
      end
    end
    $display("test_forward_chain: done, %0d errors so far", errors);
  endtask

  task automatic test_rtype_lui();
    logic [31:0] exp_v [1:5];
    clear_rom(32'h0);
    rom[0] = enc_i(6'h0F, 5'd0, 5'd1, 16'h0101);
    rom[1] = enc_i(6'h0D, 5'd1, 5'd1, 16'h0101);
    rom[2] = enc_i(6'h0D, 5'd1, 5'd2, 16'h1100);
    rom[3] = enc_r(5'd1, 5'd2, 5'd3, 6'h25);
    rom[4] = enc_r(5'd3, 5'd1, 5'd4, 6'h24);
    rom[5] = enc_r(5'd0, 5'd0, 5'd5, 6'h27);
    exp_v[1] = 32'h0101_0101; exp_v[2] = 32'h0101_1101; exp_v[3] = 32'h0101_1101;
    exp_v[4] = 32'h0101_0101; exp_v[5] = 32'hffff_ffff;
    do_reset();
    repeat (12) next_edge();
    for (int r = 1; r <= 5; r++) begin
      checks++;
      if (dut.u_regfile.regs[r] !== exp_v[r]) begin
        errors++; $display("FAIL rtype $%0d: got %h expected %h", r, dut.u_regfile.regs[r], exp_v[r]);
      end
    end
    $display("test_rtype_lui: done, %0d errors so far", errors);
  endtask

  task automatic test_zero_nop();
    logic [31:0] exp_v;
    clear_rom(32'h0);
    rom[0] = enc_i(6'h0D, 5'd0, 5'd0, 16'hffff);
    rom[1] = enc_i(6'h0D, 5'd0, 5'd7, 16'h0001);
    rom[2] = 32'h0000_0000;
    rom[3] = enc_i(6'h3F, 5'd0, 5'd1, 16'hffff);
    rom[4] = enc_r(5'd7, 5'd7, 5'd2, 6'h20);
    rom[5] = enc_i(6'h0D, 5'd0, 5'd6, 16'h1234);
    do_reset();
    repeat (14) next_edge();
    for (int r = 0; r <= 7; r++) begin
      exp_v = (r == 7) ? 32'h1 : (r == 6) ? 32'h1234 : 32'h0;
      checks++;
      if (dut.u_regfile.regs[r] !== exp_v) begin
        errors++; $display("FAIL zero_nop $%0d: got %h expected %h", r, dut.u_regfile.regs[r], exp_v);
      end
    end
    $display("test_zero_nop: done, %0d errors so far", errors);
  endtask

  task automatic test_async_reset();
    load_imm_prog();
    do_reset();
    repeat (12) next_edge();
    checks++;
    if (dut.u_regfile.regs[1] !== 32'h1100) begin
      errors++; $display("FAIL areset_pre $1: got %h expected 00001100", dut.u_regfile.regs[1]);
    end
    #4 rst = 1'b0;
    #1;
    checks++;
    if (rom_ce !== 1'b0) begin
      errors++; $display("FAIL areset_ce: got %b expected 0", rom_ce);
    end
    checks++;
    if (rom_addr !== 32'h0) begin
      errors++; $display("FAIL areset_addr: got %h expected 00000000", rom_addr);
    end
    for (int r = 1; r <= 4; r++) begin
      checks++;
      if (dut.u_regfile.regs[r] !== 32'h0) begin
        errors++; $display("FAIL areset $%0d: got %h expected 00000000", r, dut.u_regfile.regs[r]);
      end
    end
    #2 rst = 1'b1;
    check_imm_timing("refetch");
    $display("test_async_reset: done, %0d errors so far", errors);
  endtask

  initial begin
    test_reset();
    test_immediates();
    test_forward_chain();
    test_rtype_lui();
    test_zero_nop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
